// File: rtl/bayer_mosaic_tx.sv
// bayer_mosaic_tx
// Streams a raw Bayer frame out of three full-colour plane memories (R/G/B,
// one byte per pixel). Reads pixels in raster order. For each pixel it keeps
// only the channel that the CFA position selects and sends it as one byte on
// a valid/ready stream.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   start               frame request, only looked at in IDLE
//   busy                high from frame accept until the done state
//   addr, rd_en         registered read address {row,col} and its qualifier
//   rdata_r/g/b         combinational plane read data for addr
//   out_valid/out_ready stream handshake
//   data_out, out_last  Bayer sample; out_last flags the all-ones address
//   done                one-cycle pulse after the last beat is accepted
//   checksum            (BAYER_TX_CHECKSUM_EN only) 16-bit sum of accepted bytes
//
// Optional feature macro: BAYER_TX_CHECKSUM_EN
//
// state | meaning
// IDLE  | waiting for start
// FETCH | issuing reads while the output buffer has credit
// DRAIN | all reads issued, waiting for buffer and in-flight read to empty
// DONE  | done pulse, pointer cleared
module bayer_mosaic_tx #(
  parameter int ROW_BITS = 7,
  parameter int COL_BITS = 7,
  parameter int ADDR_W   = ROW_BITS + COL_BITS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic [ADDR_W-1:0] addr,
  output logic              rd_en,
  input  logic [7:0]        rdata_r,
  input  logic [7:0]        rdata_g,
  input  logic [7:0]        rdata_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        data_out,
  output logic              out_last,
  output logic              done
`ifdef BAYER_TX_CHECKSUM_EN
  ,
  output logic [15:0]       checksum
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] rd_ptr;
  logic [1:0]        fifo_cnt;
  logic [7:0]        tail_data;
  logic              tail_last;

  logic              push;
  logic              pop;
  logic [7:0]        push_data;
  logic              push_last;
  logic [1:0]        cnt_next;
  logic              can_issue;

  // addr still holds the in-flight read address on the sample edge, so the
  // CFA select taken from it lines up with the returning data.
  always_comb begin
    push_data = rdata_g;
    case ({addr[COL_BITS], addr[0]})
      2'b01:   push_data = rdata_r;
      2'b10:   push_data = rdata_b;
      default: push_data = rdata_g;
    endcase
  end

  assign push      = rd_en;
  assign push_last = &addr;
  assign pop       = out_valid & out_ready;
  assign cnt_next  = fifo_cnt + {1'b0, push} - {1'b0, pop};
  // Credit: occupancy after this edge plus the read about to be issued must not exceed 2.
  assign can_issue = (cnt_next < 2'd2);

  // Two-entry output buffer; the head register drives the stream directly.
  always_ff @(posedge clk) begin
    if (reset) begin
      fifo_cnt  <= 2'd0;
      out_valid <= 1'b0;
      data_out  <= 8'h00;
      out_last  <= 1'b0;
      tail_data <= 8'h00;
      tail_last <= 1'b0;
    end else begin
      fifo_cnt  <= cnt_next;
      out_valid <= (cnt_next != 2'd0);
      case ({push, pop})
        2'b10: begin
          if (fifo_cnt == 2'd0) begin
            data_out <= push_data;
            out_last <= push_last;
          end else begin
            tail_data <= push_data;
            tail_last <= push_last;
          end
        end
        2'b01: begin
          if (fifo_cnt == 2'd2) begin
            data_out <= tail_data;
            out_last <= tail_last;
          end else begin
            out_last <= 1'b0;
          end
        end
        2'b11: begin
          if (fifo_cnt == 2'd1) begin
            data_out <= push_data;
            out_last <= push_last;
          end else begin
            data_out  <= tail_data;
            out_last  <= tail_last;
            tail_data <= push_data;
            tail_last <= push_last;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      addr   <= '0;
      rd_en  <= 1'b0;
      rd_ptr <= '0;
      done   <= 1'b0;
      busy   <= 1'b0;
    end else begin
      done  <= 1'b0;
      rd_en <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state  <= S_FETCH;
            busy   <= 1'b1;
            rd_ptr <= '0;
          end
        end
        S_FETCH: begin
          if (can_issue) begin
            addr   <= rd_ptr;
            rd_en  <= 1'b1;
            rd_ptr <= rd_ptr + ADDR_W'(1);
            if (&rd_ptr) state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (fifo_cnt == 2'd0 && !rd_en) begin
            state <= S_DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end
        end
        default: begin
          state  <= S_IDLE;
          rd_ptr <= '0;
        end
      endcase
    end
  end

`ifdef BAYER_TX_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (reset)
      checksum <= 16'h0000;
    else if (state == S_IDLE && start)
      checksum <= 16'h0000;
    else if (pop)
      checksum <= checksum + {8'h00, data_out};
  end
`endif

endmodule

// File: tb/tb_bayer_mosaic_tx.sv
// Testbench for bayer_mosaic_tx: a scoreboard of expected {last,byte} beats
// is filled per frame and drained by a negedge monitor that also drives
// out_ready. The monitor also checks stall stability and read credit.
module tb_bayer_mosaic_tx;
  localparam int NPIX = 16384;

  logic        clk = 1'b0;
  logic        reset, start, busy, rd_en, out_valid, out_ready, out_last, done;
  logic [13:0] addr;
  logic [7:0]  rdata_r, rdata_g, rdata_b, data_out;
`ifdef BAYER_TX_CHECKSUM_EN
  logic [15:0] checksum;
`endif

  bayer_mosaic_tx dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .addr(addr),
    .rd_en(rd_en), .rdata_r(rdata_r), .rdata_g(rdata_g), .rdata_b(rdata_b),
    .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out),
    .out_last(out_last), .done(done)
`ifdef BAYER_TX_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  always #5 clk = ~clk;

  logic ones = 1'b0;
  assign rdata_r = ones ? 8'h01 : addr[7:0];
  assign rdata_g = ones ? 8'h01 : (addr[7:0] ^ 8'h55);
  assign rdata_b = ones ? 8'h01 : ~addr[7:0];

  int checks = 0, errors = 0;
  logic [8:0] sb_q[$];
  int   ready_mode = 1;
  int   cyc = 0, beat_cnt = 0, done_cnt = 0, done_cyc = 0, last_cyc = 0;
  logic [15:0] exp_sum;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_byte(input logic [13:0] a, input logic one);
    logic [7:0] lo;
    lo = a[7:0];
    if (one) return 8'h01;
    case ({a[7], a[0]})
      2'b01:   return lo;
      2'b10:   return ~lo;
      default: return lo ^ 8'h55;
    endcase
  endfunction

  task automatic load_q();
    logic [7:0]  e;
    logic [13:0] a;
    sb_q.delete();
    exp_sum  = 16'h0000;
    beat_cnt = 0;
    for (int i = 0; i < NPIX; i++) begin
      a = i[13:0];
      e = exp_byte(a, ones);
      sb_q.push_back({(i == NPIX - 1), e});
      exp_sum = exp_sum + {8'h00, e};
    end
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_beats(input int n, input int budget);
    int k = 0;
    while (beat_cnt < n && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    check("beat_wait_timeout", beat_cnt >= n, 1);
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (done_cnt == 0 && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    check("done_timeout", done_cnt != 0, 1);
    repeat (4) @(posedge clk);
    #1;
    check("single_done", done_cnt, 1);
    check("busy_after_done", busy, 0);
    check("sb_empty", sb_q.size(), 0);
    check("beat_count", beat_cnt, NPIX);
  endtask

  // Monitor + out_ready driver.
  initial begin
    int   tb_fifo;
    logic prev_rd, prev_pop, prev_stall, prev_done, pop_now;
    logic [7:0] prev_data;
    logic [8:0] e;
    tb_fifo = 0; prev_rd = 0; prev_pop = 0; prev_stall = 0; prev_done = 0; prev_data = 0;
    out_ready = 1'b1;
    forever begin
      @(negedge clk);
      case (ready_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (reset) begin
        tb_fifo = 0; prev_rd = 0; prev_pop = 0; prev_stall = 0; prev_done = 0;
      end else begin
        tb_fifo = tb_fifo + int'(prev_rd) - int'(prev_pop);
        check("valid_vs_fill", out_valid, tb_fifo != 0);
        if (rd_en) check("read_credit", (tb_fifo + 1) <= 2, 1);
        if (prev_stall) begin
          check("stall_valid", out_valid, 1);
          check("stall_data", data_out, prev_data);
        end
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
          check("done_width", prev_done, 0);
        end
        pop_now = out_valid && out_ready;
        if (pop_now) begin
          beat_cnt++;
          if (out_last) last_cyc = cyc;
          if (sb_q.size() == 0) begin
            check("sb_underflow", 1, 0);
          end else begin
            e = sb_q.pop_front();
            check("beat", {out_last, data_out}, e);
          end
        end
        prev_rd = rd_en; prev_pop = pop_now; prev_done = done;
        prev_stall = out_valid && !out_ready; prev_data = data_out;
      end
    end
  end

  initial begin
    int   rd_cnt;
    logic [31:0] seed;
    seed  = $urandom(32'd1357);
    reset = 1'b1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_addr", addr, 0);
    check("rst_rd_en", rd_en, 0);
    check("rst_valid", out_valid, 0);
    check("rst_data", data_out, 0);
    check("rst_last", out_last, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
`ifdef BAYER_TX_CHECKSUM_EN
    check("rst_checksum", checksum, 0);
`endif
    reset = 1'b0;

    // Frame A: sink always ready, latency and done timing.
    ready_mode = 1; done_cnt = 0;
    load_q();
    pulse_start();
    check("a_busy", busy, 1);
    check("a_rd_e0", rd_en, 0);
    @(posedge clk); #1;
    check("a_rd_e1", rd_en, 1);
    check("a_addr_e1", addr, 0);
    check("a_valid_e1", out_valid, 0);
    @(posedge clk); #1;
    check("a_valid_e2", out_valid, 1);
    check("a_first", data_out, 8'h55);
    wait_done(20000);
    check("a_done_lat", done_cyc - last_cyc, 2);
`ifdef BAYER_TX_CHECKSUM_EN
    check("a_checksum", checksum, exp_sum);
`endif

    // Frame B: random back-pressure plus a start while busy.
    ready_mode = 2; done_cnt = 0;
    load_q();
    pulse_start();
    wait_beats(100, 1000);
    pulse_start();
    wait_done(40000);
`ifdef BAYER_TX_CHECKSUM_EN
    check("b_checksum", checksum, exp_sum);
`endif

    // Frame C: stalled sink right after start, then abort by reset.
    ready_mode = 0; done_cnt = 0;
    load_q();
    pulse_start();
    rd_cnt = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (rd_en) rd_cnt++;
    end
    check("c_reads", rd_cnt, 2);
    check("c_rd_idle", rd_en, 0);
    check("c_valid", out_valid, 1);
    check("c_data", data_out, 8'h55);
    ready_mode = 1;
    wait_beats(5000, 8000);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); @(posedge clk); #1 reset = 1'b0;
    sb_q.delete();
    check("c_rst_busy", busy, 0);
    check("c_rst_valid", out_valid, 0);
    repeat (10) @(posedge clk);
    #1;
    check("c_no_done", done_cnt, 0);

    // Frame D: restart after abort begins at address 0.
    load_q();
    pulse_start();
    @(posedge clk); #1;
    check("d_addr0", addr, 0);
    check("d_rd", rd_en, 1);
    wait_beats(300, 1000);
    check("d_done_none", done_cnt, 0);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); @(posedge clk); #1 reset = 1'b0;
    sb_q.delete();

`ifdef BAYER_TX_CHECKSUM_EN
    // Frame E: all planes 1, checksum of a full frame.
    ones = 1'b1; done_cnt = 0;
    load_q();
    pulse_start();
    wait_done(20000);
    check("e_checksum", checksum, 16'h4000);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
